convergence_sequencer: RTL and testbench



---
 rtl/kmeans_ctrl_pkg.sv | 23 ++
 rtl/convergence_sequencer.sv | 187 ++++++++++++++++++
 tb/tb_convergence_sequencer.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/kmeans_ctrl_pkg.sv
// Shared types and constants for the k-means control blocks.
// The convergence sequencer state encoding lives here so other controllers can decode it.
package kmeans_ctrl_pkg;

  localparam int CENTROID_NUM   = 8;
  localparam int CENT_IDX_WIDTH = 3;
  localparam int ITER_WIDTH     = 8;
  localparam logic [CENT_IDX_WIDTH-1:0] LAST_CENT = 3'd7;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    REQ,
    ISSUE,
    WRITE,
    DECIDE
  } conv_seq_state_t;

  function automatic logic [ITER_WIDTH-1:0] sat_inc(input logic [ITER_WIDTH-1:0] v);
    return (&v) ? v : v + ITER_WIDTH'(1);
  endfunction

endpackage

// File: rtl/convergence_sequencer.sv
// Steps the convergence datapath through all centroids after each accumulation pass and
// reports converge/iterate. Optional iteration limit: define CONV_SEQ_MAX_ITER_EN.
module convergence_sequencer
  import kmeans_ctrl_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic                      abort,
  output logic                      mean_req,
  output logic [CENT_IDX_WIDTH-1:0] mean_idx,
  input  logic                      mean_valid,
  output logic                      mean_ack,
  output logic [CENT_IDX_WIDTH-1:0] cent_num,
  output logic                      convergence_reg_en,
  output logic                      convergence_regs_reset_n,
  input  logic                      has_converged,
  input  logic                      converge_res_available,
  output logic                      centroid_wr_en,
  output logic [CENT_IDX_WIDTH-1:0] centroid_wr_idx,
  input  logic [ITER_WIDTH-1:0]     max_iter,
  output logic                      iter_next,
  output logic                      done,
  output logic                      converged,
  output logic [ITER_WIDTH-1:0]     iter_count,
  output logic                      seq_error
);

  conv_seq_state_t state_q, state_d;
  logic [CENT_IDX_WIDTH-1:0] k_q, k_d;
  logic [ITER_WIDTH-1:0]     iter_count_q, iter_count_d, iter_inc;
  logic converged_q, converged_d;
  logic seq_error_q, seq_error_d;
  logic fin_q, fin_d;
  logic done_q, done_d;
  logic iter_next_q, iter_next_d;
  logic mean_req_q, mean_req_d;
  logic mean_ack_q, mean_ack_d;
  logic reg_en_q, reg_en_d;
  logic regs_rst_n_q, regs_rst_n_d;
  logic wr_en_q, wr_en_d;
  logic [CENT_IDX_WIDTH-1:0] mean_idx_q, mean_idx_d;
  logic [CENT_IDX_WIDTH-1:0] cent_num_q, cent_num_d;
  logic [CENT_IDX_WIDTH-1:0] wr_idx_q, wr_idx_d;
  logic verdict, at_limit;

  assign iter_inc = sat_inc(iter_count_q);
  assign verdict  = has_converged && converge_res_available;

`ifdef CONV_SEQ_MAX_ITER_EN
  assign at_limit = (max_iter != '0) && (iter_inc >= max_iter);
`else
  logic unused_max_iter;
  assign unused_max_iter = ^max_iter;
  assign at_limit        = 1'b0;
`endif

  always_comb begin
    state_d      = state_q;
    k_d          = k_q;
    iter_count_d = iter_count_q;
    converged_d  = converged_q;
    seq_error_d  = seq_error_q;
    fin_d        = fin_q;
    done_d       = 1'b0;
    iter_next_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = CLEAR;
          converged_d = 1'b0;
          // fin_q marks that the last result was final, so a fresh run begins
          if (fin_q) begin
            iter_count_d = '0;
            seq_error_d  = 1'b0;
            fin_d        = 1'b0;
          end
        end
      end
      CLEAR: begin
        k_d     = '0;
        state_d = REQ;
      end
      REQ: begin
        if (mean_valid) state_d = ISSUE;
      end
      ISSUE: state_d = WRITE;
      WRITE: begin
        if (k_q != LAST_CENT) begin
          k_d     = k_q + CENT_IDX_WIDTH'(1);
          state_d = REQ;
        end else begin
          // Verdict is resolved here so the DECIDE-cycle outputs are already registered
          state_d      = DECIDE;
          iter_count_d = iter_inc;
          if (!converge_res_available) seq_error_d = 1'b1;
          if (verdict) begin
            converged_d = 1'b1;
            done_d      = 1'b1;
            fin_d       = 1'b1;
          end else if (at_limit) begin
            done_d = 1'b1;
            fin_d  = 1'b1;
          end else begin
            iter_next_d = 1'b1;
          end
        end
      end
      DECIDE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase

    if (abort) begin
      state_d      = IDLE;
      k_d          = k_q;
      iter_count_d = iter_count_q;
      converged_d  = converged_q;
      seq_error_d  = seq_error_q;
      fin_d        = fin_q;
      done_d       = 1'b0;
      iter_next_d  = 1'b0;
    end

    mean_req_d   = (state_d == REQ);
    mean_idx_d   = (state_d == REQ) ? k_d : '0;
    mean_ack_d   = (state_d == ISSUE);
    reg_en_d     = (state_d == ISSUE);
    cent_num_d   = (state_d == ISSUE) ? k_d : '0;
    wr_en_d      = (state_d == WRITE);
    wr_idx_d     = (state_d == WRITE) ? k_d : '0;
    regs_rst_n_d = !((state_d == IDLE) || (state_d == CLEAR));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      k_q          <= '0;
      iter_count_q <= '0;
      converged_q  <= 1'b0;
      seq_error_q  <= 1'b0;
      fin_q        <= 1'b1;
      done_q       <= 1'b0;
      iter_next_q  <= 1'b0;
      mean_req_q   <= 1'b0;
      mean_idx_q   <= '0;
      mean_ack_q   <= 1'b0;
      reg_en_q     <= 1'b0;
      cent_num_q   <= '0;
      wr_en_q      <= 1'b0;
      wr_idx_q     <= '0;
      regs_rst_n_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      k_q          <= k_d;
      iter_count_q <= iter_count_d;
      converged_q  <= converged_d;
      seq_error_q  <= seq_error_d;
      fin_q        <= fin_d;
      done_q       <= done_d;
      iter_next_q  <= iter_next_d;
      mean_req_q   <= mean_req_d;
      mean_idx_q   <= mean_idx_d;
      mean_ack_q   <= mean_ack_d;
      reg_en_q     <= reg_en_d;
      cent_num_q   <= cent_num_d;
      wr_en_q      <= wr_en_d;
      wr_idx_q     <= wr_idx_d;
      regs_rst_n_q <= regs_rst_n_d;
    end
  end

  assign mean_req                 = mean_req_q;
  assign mean_idx                 = mean_idx_q;
  assign mean_ack                 = mean_ack_q;
  assign cent_num                 = cent_num_q;
  assign convergence_reg_en       = reg_en_q;
  assign convergence_regs_reset_n = regs_rst_n_q;
  assign centroid_wr_en           = wr_en_q;
  assign centroid_wr_idx          = wr_idx_q;
  assign iter_next                = iter_next_q;
  assign done                     = done_q;
  assign converged                = converged_q;
  assign iter_count               = iter_count_q;
  assign seq_error                = seq_error_q;

endmodule

// File: tb/tb_convergence_sequencer.sv
// Directed bench for convergence_sequencer: pass latency, handshake stall, abort, reset, seq_error.
module tb_convergence_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       mean_valid = 1'b1;
  logic       has_converged = 1'b0;
  logic       converge_res_available = 1'b1;
  logic [7:0] max_iter = 8'd0;
  logic       mean_req, mean_ack, convergence_reg_en, convergence_regs_reset_n;
  logic       centroid_wr_en, iter_next, done, converged, seq_error;
  logic [2:0] mean_idx, cent_num, centroid_wr_idx;
  logic [7:0] iter_count;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  convergence_sequencer dut (
    .clk                      (clk),
    .rst_n                    (rst_n),
    .start                    (start),
    .abort                    (abort),
    .mean_req                 (mean_req),
    .mean_idx                 (mean_idx),
    .mean_valid               (mean_valid),
    .mean_ack                 (mean_ack),
    .cent_num                 (cent_num),
    .convergence_reg_en       (convergence_reg_en),
    .convergence_regs_reset_n (convergence_regs_reset_n),
    .has_converged            (has_converged),
    .converge_res_available   (converge_res_available),
    .centroid_wr_en           (centroid_wr_en),
    .centroid_wr_idx          (centroid_wr_idx),
    .max_iter                 (max_iter),
    .iter_next                (iter_next),
    .done                     (done),
    .converged                (converged),
    .iter_count               (iter_count),
    .seq_error                (seq_error)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_mean_req"}, 32'(mean_req), 0);
    check({pfx, "_mean_idx"}, 32'(mean_idx), 0);
    check({pfx, "_mean_ack"}, 32'(mean_ack), 0);
    check({pfx, "_cent_num"}, 32'(cent_num), 0);
    check({pfx, "_reg_en"}, 32'(convergence_reg_en), 0);
    check({pfx, "_regs_rst_n"}, 32'(convergence_regs_reset_n), 0);
    check({pfx, "_wr_en"}, 32'(centroid_wr_en), 0);
    check({pfx, "_wr_idx"}, 32'(centroid_wr_idx), 0);
    check({pfx, "_done"}, 32'(done), 0);
    check({pfx, "_iter_next"}, 32'(iter_next), 0);
    check({pfx, "_converged"}, 32'(converged), 0);
    check({pfx, "_iter_count"}, 32'(iter_count), 0);
    check({pfx, "_seq_error"}, 32'(seq_error), 0);
  endtask

  // Caller sits #1 after a rising edge. lat counts edges from the one that samples start.
  task automatic run_pass(input bit withhold, output int lat, output bit saw_done, output bit saw_next);
    int  wexp = 0;
    int  acks = 0;
    int  hold = 0;
    bit  bad  = 1'b0;
    lat = 0; saw_done = 1'b0; saw_next = 1'b0;
    start = 1'b1;
    for (int c = 1; c <= 100 && !(saw_done || saw_next); c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      lat = c;
      if (c == 1) begin
        check("clear_regs_rst_n", 32'(convergence_regs_reset_n), 0);
        check("clear_converged", 32'(converged), 0);
      end
      if (c == 2) begin
        check("req0_mean_req", 32'(mean_req), 1);
        check("req0_mean_idx", 32'(mean_idx), 0);
        check("req0_regs_rst_n", 32'(convergence_regs_reset_n), 1);
      end
      if (mean_ack) acks++;
      if ((cent_num != 3'd0 && !convergence_reg_en) || (mean_ack != convergence_reg_en)) bad = 1'b1;
      if (centroid_wr_en) begin
        check("wr_idx", 32'(centroid_wr_idx), 32'(wexp));
        if (cent_num != 3'd0) bad = 1'b1;
        if (withhold && centroid_wr_idx == 3'd2) mean_valid = 1'b0;
        wexp++;
      end
      if (withhold && mean_req && mean_idx == 3'd3) begin
        hold++;
        if (hold <= 5) begin
          check("hold_mean_req", 32'(mean_req), 1);
          check("hold_cent_num", 32'(cent_num), 0);
          check("hold_reg_en", 32'(convergence_reg_en), 0);
          check("hold_mean_ack", 32'(mean_ack), 0);
        end
        if (hold == 6) mean_valid = 1'b1;
      end
      if (done) saw_done = 1'b1;
      if (iter_next) saw_next = 1'b1;
    end
    mean_valid = 1'b1;
    if (!(saw_done || saw_next)) check("pass_timeout", 1, 0);
    check("ack_count", 32'(acks), 8);
    check("wr_count", 32'(wexp), 8);
    check("cent_num_gating", 32'(bad), 0);
  endtask

  initial begin
    int lat;
    bit sd, sn;
    int seen;

    #2 rst_n = 1'b0;
    #1 check_reset_outputs("rst");
    #19 rst_n = 1'b1;
    @(posedge clk); #1;

    // Not converged: iterate
    has_converged = 1'b0;
    run_pass(1'b0, lat, sd, sn);
    check("p1_latency", 32'(lat), 26);
    check("p1_done", 32'(sd), 0);
    check("p1_iter_next", 32'(sn), 1);
    check("p1_iter_count", 32'(iter_count), 1);
    check("p1_converged", 32'(converged), 0);
    @(posedge clk); #1;

    // Stall on k=3 then converge
    has_converged = 1'b1;
    run_pass(1'b1, lat, sd, sn);
    check("p2_latency", 32'(lat), 31);
    check("p2_done", 32'(sd), 1);
    check("p2_iter_next", 32'(sn), 0);
    check("p2_converged", 32'(converged), 1);
    check("p2_iter_count", 32'(iter_count), 2);
    check("p2_seq_error", 32'(seq_error), 0);
    @(posedge clk); #1;
    check("p2_done_pulse", 32'(done), 0);
    check("p2_converged_sticky", 32'(converged), 1);
    @(posedge clk); #1;

    // New run after done restarts the counter
    has_converged = 1'b0;
    run_pass(1'b0, lat, sd, sn);
    check("p3_iter_next", 32'(sn), 1);
    check("p3_iter_count", 32'(iter_count), 1);
    check("p3_converged", 32'(converged), 0);
    @(posedge clk); #1;

    // Abort in ISSUE for k=4
    start = 1'b1;
    seen = 0;
    for (int c = 0; c < 100 && seen == 0; c++) begin
      @(posedge clk); #1;
      start = 1'b0;
      if (mean_ack && cent_num == 3'd4) seen = 1;
    end
    check("abort_reached_issue4", 32'(seen), 1);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    check("abort_regs_rst_n", 32'(convergence_regs_reset_n), 0);
    check("abort_mean_req", 32'(mean_req), 0);
    check("abort_reg_en", 32'(convergence_reg_en), 0);
    check("abort_wr_en", 32'(centroid_wr_en), 0);
    seen = 0;
    for (int c = 0; c < 30; c++) begin
      if (done || iter_next || mean_req) seen = 1;
      @(posedge clk); #1;
    end
    check("abort_no_pulse", 32'(seen), 0);
    check("abort_iter_count", 32'(iter_count), 1);

    // Verdict unavailable: seq_error, treated as not converged
    has_converged = 1'b1;
    converge_res_available = 1'b0;
    run_pass(1'b0, lat, sd, sn);
    check("p5_done", 32'(sd), 0);
    check("p5_iter_next", 32'(sn), 1);
    check("p5_seq_error", 32'(seq_error), 1);
    check("p5_converged", 32'(converged), 0);
    check("p5_iter_count", 32'(iter_count), 2);
    converge_res_available = 1'b1;
    @(posedge clk); #1;

    // Async reset mid-pass
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #4 rst_n = 1'b0;
    #1 check_reset_outputs("arst");
    #7 rst_n = 1'b1;
    @(posedge clk); #1;

    // Iteration limit of 3, never converging
    has_converged = 1'b0;
    max_iter = 8'd3;
    run_pass(1'b0, lat, sd, sn);
    check("lim1_iter_next", 32'(sn), 1);
    @(posedge clk); #1;
    run_pass(1'b0, lat, sd, sn);
    check("lim2_iter_next", 32'(sn), 1);
    @(posedge clk); #1;
    run_pass(1'b0, lat, sd, sn);
`ifdef CONV_SEQ_MAX_ITER_EN
    check("lim3_done", 32'(sd), 1);
    check("lim3_iter_next", 32'(sn), 0);
`else
    check("lim3_done", 32'(sd), 0);
    check("lim3_iter_next", 32'(sn), 1);
`endif
    check("lim3_converged", 32'(converged), 0);
    check("lim3_iter_count", 32'(iter_count), 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected test end");
    $fatal(1, "watchdog");
  end

endmodule
